ysyx_24080014_pc_gen: RTL and testbench
=======================================

# ysyx_24080014_pc_gen

Parametrised program-counter generator for the multi-cycle core. It holds the architectural PC, offers it to the IFU over a valid/ready handshake, and waits for the instruction to retire or trap before loading the next PC. It also counts retired instructions, emits a one-cycle commit strobe (with the committed PC) for the difftest harness, halts on request, and flags protocol and alignment errors.

## Interface
- `XLEN`, 32, PC/address width.
- `RESET_VECTOR`, 32'h8000_0000, PC value after reset (XLEN bits).
- `IALIGN_BITS`, 2, number of low PC bits that must be zero (2 = 4-byte instructions).
- `CNT_W`, 64, width of the retired-instruction counter.
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `out_valid`  out  1  PC offered to IFU.
- `out_ready`  in  1  IFU accepts PC.
- `pc`  out  XLEN  current PC.
- `retire_valid`  in  1  current instruction retired; take `retire_next_pc`.
- `retire_next_pc`  in  XLEN  next sequential/branch target.
- `trap_valid`  in  1  current instruction trapped; take `trap_vector`.
- `trap_vector`  in  XLEN  trap target (mtvec/mepc).
- `halt_req`  in  1  stop after the current retire/trap (ebreak).
- `commit_valid`  out  1  one-cycle strobe: an instruction completed.
- `commit_pc`  out  XLEN  PC of the completed instruction.
- `commit_trap`  out  1  the completion was a trap.
- `instret`  out  CNT_W  completed-instruction count.
- `halted`  out  1  block is in HALTED.
- `misalign_err`  out  1  sticky; a loaded PC had nonzero low `IALIGN_BITS`.
- `protocol_err`  out  1  sticky; retire/trap arrived outside WAIT.

## Operation
- States: BOOT, ISSUE, WAIT, HALTED.
- Reset (any state, any cycle): state=BOOT, `pc`=RESET_VECTOR, `out_valid`=0, `commit_valid`=0, `commit_pc`=0, `commit_trap`=0, `instret`=0, `halted`=0, both error flags 0. Any in-flight handshake or retire is abandoned.
- BOOT: `out_valid`=0, then unconditionally go to ISSUE on the next cycle.
- ISSUE: `out_valid`=1 and `pc` held stable until `out_ready`=1. On `out_valid & out_ready`, go to WAIT. `out_valid` never drops before the handshake.
- WAIT: `out_valid`=0.
  - If `trap_valid`: `pc`<=`trap_vector` and set `commit_trap`=1. Trap has priority when both trap and retire are high.
  - Else if `retire_valid`: `pc`<=`retire_next_pc` and set `commit_trap`=0.
  - On either event: `commit_valid`<=1, `commit_pc`<=old `pc`, `instret`<=`instret`+1, which wraps modulo 2^CNT_W.
  - Next state is HALTED if `halt_req` is high in the same cycle, else ISSUE.
  - With neither event, stay in WAIT; `halt_req` alone is ignored.
- HALTED: `out_valid`=0 and `halted`=1. Only `rst` exits this state. Retire/trap here set `protocol_err`.
- `commit_valid` is a single-cycle pulse; it deasserts the cycle after it is set unless another completion occurs.
- `misalign_err` is set when the value loaded into `pc` has nonzero low `IALIGN_BITS`. The PC is still loaded unchanged; no auto-correction.
- `protocol_err` is set by `retire_valid | trap_valid` in BOOT, ISSUE or HALTED. The event is otherwise ignored: `pc`, `instret` and commit outputs are unchanged.

## Timing
- Reset → first `out_valid`=1: 2 cycles after `rst` deasserts (BOOT, then ISSUE).
- Handshake in cycle N → WAIT in cycle N+1.
- Retire in cycle M (WAIT):
  - cycle M+1: new `pc` visible, `commit_valid`=1, `instret` incremented, `out_valid`=1.
  - Minimum loop is 2 cycles per instruction with `out_ready` tied high and retire on the first WAIT cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset/boot: hold `rst`=1 for 3 cycles, then release → `pc`=0x8000_0000, `out_valid`=0 for 1 cycle then 1; `instret`=0; all flags 0.
- Sequential run: `out_ready`=1, retire each WAIT cycle with `retire_next_pc`=`pc`+4 for 10 instructions → PCs 0x8000_0000…0x8000_0024, 10 `commit_valid` pulses, `commit_pc` matching each, `instret`=10.
- Backpressure and priority: `out_ready`=0 for 5 cycles → `pc` stable and `out_valid` held. Then in WAIT assert `trap_valid` (vector 0x8000_1000) together with `retire_valid` (0x8000_0004) → `pc`=0x8000_1000, `commit_trap`=1, `instret`+1.
- Halt: `halt_req`=1 with retire at `pc`=0x8000_0008 → `halted`=1, `out_valid` stays 0 for 20 cycles, `commit_pc`=0x8000_0008; asserting `rst` → BOOT, `pc`=0x8000_0000.
- Errors: `retire_valid` pulsed in ISSUE → `protocol_err`=1, `instret` unchanged. Retire to 0x8000_0002 → `pc`=0x8000_0002, `misalign_err`=1 and stays 1 until reset.
- Wrap/reset mid-op: with `CNT_W`=4, 16 retires → `instret`=0. Asserting `rst` in WAIT with `retire_valid`=1 in the same cycle → reset wins, `commit_valid`=0, `instret`=0.

Source files
------------

// File: rtl/ysyx_24080014_pc_gen_if.sv
// Fetch handshake between the PC generator and the IFU: the PC generator
// offers a PC with out_valid and the IFU accepts it with out_ready.
interface ysyx_24080014_pc_gen_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc;

  modport master (
    output out_valid,
    output pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  pc,
    output out_ready
  );
endinterface

// File: rtl/ysyx_24080014_pc_gen.sv
// Program-counter generator for the multi-cycle core: issues the PC to the IFU,
// waits for retire/trap, reports commits and counts retired instructions.
module ysyx_24080014_pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
  parameter int unsigned     IALIGN_BITS  = 2,
  parameter int unsigned     CNT_W        = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24080014_pc_gen_if.master ifu,
  input  logic                  retire_valid_i,
  input  logic [XLEN-1:0]       retire_next_pc_i,
  input  logic                  trap_valid_i,
  input  logic [XLEN-1:0]       trap_vector_i,
  input  logic                  halt_req_i,
  output logic                  commit_valid_o,
  output logic [XLEN-1:0]       commit_pc_o,
  output logic                  commit_trap_o,
  output logic [CNT_W-1:0]      instret_o,
  output logic                  halted_o,
  output logic                  misalign_err_o,
  output logic                  protocol_err_o
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic              commit_valid_q, commit_valid_d;
  logic [XLEN-1:0]   commit_pc_q, commit_pc_d;
  logic              commit_trap_q, commit_trap_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              halted_q, halted_d;
  logic              misalign_q, misalign_d;
  logic              protocol_q, protocol_d;
  logic              any_event_s;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < IALIGN_BITS; i++) begin
      bad = bad | addr[i];
    end
    return bad;
  endfunction

  assign any_event_s = retire_valid_i | trap_valid_i;

  // Next-state and next-output computation for the issue/wait loop.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    commit_trap_d  = commit_trap_q;
    instret_d      = instret_q;
    misalign_d     = misalign_q;
    protocol_d     = protocol_q;

    case (state_q)
      ST_BOOT: begin
        state_d    = ST_ISSUE;
        protocol_d = protocol_q | any_event_s;
      end
      ST_ISSUE: begin
        protocol_d = protocol_q | any_event_s;
        if (ifu.out_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (any_event_s) begin
          // Trap wins over a simultaneous retire.
          if (trap_valid_i) begin
            pc_d          = trap_vector_i;
            commit_trap_d = 1'b1;
          end else begin
            pc_d          = retire_next_pc_i;
            commit_trap_d = 1'b0;
          end
          commit_valid_d = 1'b1;
          commit_pc_d    = pc_q;
          instret_d      = instret_q + CNT_W'(1'b1);
          misalign_d     = misalign_q | is_misaligned(pc_d);
          if (halt_req_i) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HALTED: begin
        state_d    = ST_HALTED;
        protocol_d = protocol_q | any_event_s;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    out_valid_d = (state_d == ST_ISSUE);
    halted_d    = (state_d == ST_HALTED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      out_valid_q    <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_trap_q  <= 1'b0;
      instret_q      <= '0;
      halted_q       <= 1'b0;
      misalign_q     <= 1'b0;
      protocol_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      commit_trap_q  <= commit_trap_d;
      instret_q      <= instret_d;
      halted_q       <= halted_d;
      misalign_q     <= misalign_d;
      protocol_q     <= protocol_d;
    end
  end

  assign ifu.out_valid   = out_valid_q;
  assign ifu.pc          = pc_q;
  assign commit_valid_o  = commit_valid_q;
  assign commit_pc_o     = commit_pc_q;
  assign commit_trap_o   = commit_trap_q;
  assign instret_o       = instret_q;
  assign halted_o        = halted_q;
  assign misalign_err_o  = misalign_q;
  assign protocol_err_o  = protocol_q;

endmodule

// File: tb/tb_ysyx_24080014_pc_gen.sv
// Directed self-checking bench for ysyx_24080014_pc_gen (4-bit counter instance).
module tb_ysyx_24080014_pc_gen;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        retire_valid;
  logic [31:0] retire_next_pc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        halt_req;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        commit_trap;
  logic [3:0]  instret;
  logic        halted;
  logic        misalign_err;
  logic        protocol_err;
  int          checks;
  int          failures;
  logic [31:0] exp_pc;

  ysyx_24080014_pc_gen_if #(.XLEN(32)) ifu ();

  ysyx_24080014_pc_gen #(
    .XLEN(32), .RESET_VECTOR(RV), .IALIGN_BITS(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ifu(ifu),
    .retire_valid_i(retire_valid), .retire_next_pc_i(retire_next_pc),
    .trap_valid_i(trap_valid), .trap_vector_i(trap_vector),
    .halt_req_i(halt_req),
    .commit_valid_o(commit_valid), .commit_pc_o(commit_pc),
    .commit_trap_o(commit_trap), .instret_o(instret),
    .halted_o(halted), .misalign_err_o(misalign_err),
    .protocol_err_o(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifu.out_ready = 1'b0; retire_valid = 1'b0; trap_valid = 1'b0;
    halt_req = 1'b0; retire_next_pc = 32'h0; trap_vector = 32'h0;
    repeat (3) step();
    checks++; if (ifu.pc !== RV) begin failures++; $display("FAIL reset_pc actual=%h required=%h", ifu.pc, RV); end
    checks++; if (ifu.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", ifu.out_valid); end
    checks++; if (instret !== 4'd0) begin failures++; $display("FAIL reset_instret actual=%0d required=0", instret); end
    checks++; if ({commit_valid, commit_trap, halted, misalign_err, protocol_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags actual=%b required=00000", {commit_valid, commit_trap, halted, misalign_err, protocol_err}); end
    checks++; if (commit_pc !== 32'h0) begin failures++; $display("FAIL reset_commit_pc actual=%h required=0", commit_pc); end
    rst = 1'b0;
    checks++; if (ifu.out_valid !== 1'b0) begin failures++; $display("FAIL boot_out_valid actual=%b required=0", ifu.out_valid); end
    step();
    checks++; if (ifu.out_valid !== 1'b1) begin failures++; $display("FAIL issue_out_valid actual=%b required=1", ifu.out_valid); end
    checks++; if (ifu.pc !== RV) begin failures++; $display("FAIL issue_pc actual=%h required=%h", ifu.pc, RV); end
  endtask

  task automatic test_sequential();
    ifu.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_pc = RV + 32'(4 * i);
      checks++; if (ifu.out_valid !== 1'b1 || ifu.pc !== exp_pc) begin
        failures++; $display("FAIL seq_issue[%0d] actual=%b/%h required=1/%h", i, ifu.out_valid, ifu.pc, exp_pc); end
      step();
      checks++; if (ifu.out_valid !== 1'b0) begin failures++; $display("FAIL seq_wait_valid[%0d] actual=%b required=0", i, ifu.out_valid); end
      retire_valid = 1'b1; retire_next_pc = exp_pc + 32'd4;
      step();
      retire_valid = 1'b0;
      checks++; if (commit_valid !== 1'b1 || commit_pc !== exp_pc || commit_trap !== 1'b0) begin
        failures++; $display("FAIL seq_commit[%0d] actual=%b/%h/%b required=1/%h/0", i, commit_valid, commit_pc, commit_trap, exp_pc); end
      checks++; if (ifu.pc !== exp_pc + 32'd4 || instret !== 4'(i + 1)) begin
        failures++; $display("FAIL seq_pc_cnt[%0d] actual=%h/%0d required=%h/%0d", i, ifu.pc, instret, exp_pc + 32'd4, i + 1); end
    end
    ifu.out_ready = 1'b0;
    step();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL seq_pulse_drop actual=%b required=0", commit_valid); end
    checks++; if (instret !== 4'd10 || ifu.pc !== 32'h8000_0028) begin
      failures++; $display("FAIL seq_final actual=%0d/%h required=10/80000028", instret, ifu.pc); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (ifu.out_valid !== 1'b1 || ifu.pc !== 32'h8000_0028) begin
        failures++; $display("FAIL bp_hold[%0d] actual=%b/%h required=1/80000028", i, ifu.out_valid, ifu.pc); end
    end
    ifu.out_ready = 1'b1; step(); ifu.out_ready = 1'b0;
    halt_req = 1'b1;
    repeat (2) step();
    halt_req = 1'b0;
    checks++; if (ifu.out_valid !== 1'b0 || halted !== 1'b0 || commit_valid !== 1'b0 || ifu.pc !== 32'h8000_0028) begin
      failures++; $display("FAIL wait_idle actual=%b/%b/%b/%h required=0/0/0/80000028", ifu.out_valid, halted, commit_valid, ifu.pc); end
    trap_valid = 1'b1; trap_vector = 32'h8000_1000;
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0004;
    step();
    trap_valid = 1'b0; retire_valid = 1'b0;
    checks++; if (ifu.pc !== 32'h8000_1000) begin failures++; $display("FAIL trap_pc actual=%h required=80001000", ifu.pc); end
    checks++; if (commit_trap !== 1'b1 || commit_valid !== 1'b1 || commit_pc !== 32'h8000_0028) begin
      failures++; $display("FAIL trap_commit actual=%b/%b/%h required=1/1/80000028", commit_trap, commit_valid, commit_pc); end
    checks++; if (instret !== 4'd11 || ifu.out_valid !== 1'b1) begin
      failures++; $display("FAIL trap_cnt actual=%0d/%b required=11/1", instret, ifu.out_valid); end
  endtask

  task automatic test_halt();
    ifu.out_ready = 1'b1;
    step();
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0008;
    step();
    retire_valid = 1'b0;
    checks++; if (commit_trap !== 1'b0 || ifu.pc !== 32'h8000_0008) begin
      failures++; $display("FAIL halt_pre actual=%b/%h required=0/80000008", commit_trap, ifu.pc); end
    step();
    retire_valid = 1'b1; retire_next_pc = 32'h8000_000C; halt_req = 1'b1;
    step();
    retire_valid = 1'b0; halt_req = 1'b0;
    checks++; if (halted !== 1'b1 || ifu.out_valid !== 1'b0) begin
      failures++; $display("FAIL halt_enter actual=%b/%b required=1/0", halted, ifu.out_valid); end
    checks++; if (commit_valid !== 1'b1 || commit_pc !== 32'h8000_0008 || instret !== 4'd13) begin
      failures++; $display("FAIL halt_commit actual=%b/%h/%0d required=1/80000008/13", commit_valid, commit_pc, instret); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (ifu.out_valid !== 1'b0 || halted !== 1'b1 || commit_valid !== 1'b0) begin
        failures++; $display("FAIL halt_stay[%0d] actual=%b/%b/%b required=0/1/0", i, ifu.out_valid, halted, commit_valid); end
    end
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0100;
    step();
    retire_valid = 1'b0;
    checks++; if (protocol_err !== 1'b1 || instret !== 4'd13 || ifu.pc !== 32'h8000_000C || commit_valid !== 1'b0) begin
      failures++; $display("FAIL halt_protocol actual=%b/%0d/%h/%b required=1/13/8000000c/0", protocol_err, instret, ifu.pc, commit_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ifu.pc !== RV || halted !== 1'b0 || protocol_err !== 1'b0 || ifu.out_valid !== 1'b0 || instret !== 4'd0) begin
      failures++; $display("FAIL halt_reset actual=%h/%b/%b/%b/%0d required=%h/0/0/0/0", ifu.pc, halted, protocol_err, ifu.out_valid, instret, RV); end
    step();
    checks++; if (ifu.out_valid !== 1'b1) begin failures++; $display("FAIL halt_reboot actual=%b required=1", ifu.out_valid); end
  endtask

  task automatic test_errors();
    ifu.out_ready = 1'b0;
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0040;
    step();
    retire_valid = 1'b0;
    checks++; if (protocol_err !== 1'b1 || instret !== 4'd0 || ifu.pc !== RV) begin
      failures++; $display("FAIL issue_protocol actual=%b/%0d/%h required=1/0/%h", protocol_err, instret, ifu.pc, RV); end
    checks++; if (commit_valid !== 1'b0 || ifu.out_valid !== 1'b1) begin
      failures++; $display("FAIL issue_protocol_side actual=%b/%b required=0/1", commit_valid, ifu.out_valid); end
    ifu.out_ready = 1'b1;
    step();
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0002;
    step();
    retire_valid = 1'b0;
    checks++; if (ifu.pc !== 32'h8000_0002 || misalign_err !== 1'b1) begin
      failures++; $display("FAIL misalign_set actual=%h/%b required=80000002/1", ifu.pc, misalign_err); end
    step();
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0004;
    step();
    retire_valid = 1'b0;
    checks++; if (misalign_err !== 1'b1 || ifu.pc !== 32'h8000_0004 || instret !== 4'd2) begin
      failures++; $display("FAIL misalign_sticky actual=%b/%h/%0d required=1/80000004/2", misalign_err, ifu.pc, instret); end
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b1; step(); rst = 1'b0; step();
    ifu.out_ready = 1'b1;
    exp_pc = RV;
    for (int i = 0; i < 16; i++) begin
      step();
      retire_valid = 1'b1; retire_next_pc = exp_pc + 32'd4;
      step();
      retire_valid = 1'b0;
      exp_pc = exp_pc + 32'd4;
      checks++; if (instret !== 4'(i + 1) || ifu.pc !== exp_pc) begin
        failures++; $display("FAIL wrap_cnt[%0d] actual=%0d/%h required=%0d/%h", i, instret, ifu.pc, 4'(i + 1), exp_pc); end
    end
    step();
    retire_valid = 1'b1; retire_next_pc = exp_pc + 32'd4;
    step();
    retire_valid = 1'b0;
    checks++; if (instret !== 4'd1) begin failures++; $display("FAIL wrap_next actual=%0d required=1", instret); end
    step();
    retire_valid = 1'b1; retire_next_pc = 32'h8000_0200; rst = 1'b1;
    step();
    retire_valid = 1'b0; rst = 1'b0;
    checks++; if (commit_valid !== 1'b0 || instret !== 4'd0 || ifu.pc !== RV || ifu.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_op actual=%b/%0d/%h/%b required=0/0/%h/0", commit_valid, instret, ifu.pc, ifu.out_valid, RV); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_halt();
    test_errors();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
